// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, FSM state type and flag bit positions
// for the sequential ALU unit.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_LSH  = 4'h2;
  localparam logic [3:0] OP_RSH  = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_CMP  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_NAND = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_NOR  = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  localparam int FLAG_COUT = 0;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_NEG  = 2;
  localparam int FLAG_OVF  = 3;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq_unit.
// master = producer/consumer side, slave = the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       opcode;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] out_hi;
  logic [3:0]       flags;

  modport master (
    output in_valid, op_a, op_b, opcode, cin,
    output out_ready,
    input  in_ready, out_valid, out_data,
    input  out_hi, flags
  );

  modport slave (
    input  in_valid, op_a, op_b, opcode, cin,
    input  out_ready,
    output in_ready, out_valid, out_data,
    output out_hi, flags
  );
endinterface

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// Only instantiated when ALU_SEQ_MUL_EN is defined.
module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] p_hi,
  output logic [WIDTH-1:0] p_lo
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mc_q, mc_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    mc_d   = mc_q;
    sum    = '0;
    done   = 1'b0;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      hi_d   = '0;
      lo_d   = b;
      mc_d   = a;
    end else if (busy_q) begin
      // add multiplicand into the high half, then shift {c,hi,lo} right
      sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : '0);
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        busy_d = 1'b0;
        done   = 1'b1;
      end
    end
  end

  assign p_hi = hi_d;
  assign p_lo = lo_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      mc_q   <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      mc_q   <= mc_d;
    end
  end
endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU with valid/ready handshake and registered result.
// Define ALU_SEQ_MUL_EN to include the iterative multiplier (opcode A).
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [3:0]       flags_q, flags_d;

  logic [WIDTH-1:0] a, b, res;
  logic [WIDTH:0]   add_s, sub_s;
  logic             cout, ovf, accept;
  logic [3:0]       alu_flags;

  assign a = bus.op_a;
  assign b = bus.op_b;

  always_comb begin
    add_s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, bus.cin};
    sub_s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, bus.cin};
    res   = '0;
    cout  = 1'b0;
    ovf   = 1'b0;
    case (bus.opcode)
      OP_ADD: begin
        {cout, res} = add_s;
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        {cout, res} = sub_s;
        ovf = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_LSH: begin
        res  = {a[WIDTH-2:0], bus.cin};
        cout = a[WIDTH-1];
      end
      OP_RSH: begin
        res  = {bus.cin, a[WIDTH-1:1]};
        cout = a[0];
      end
      OP_XOR:  res = a ^ b;
      OP_CMP: begin
        unique case (1'b1)
          (a == b): res = WIDTH'(1);
          (a > b):  res = WIDTH'(2);
          (a < b):  res = WIDTH'(3);
        endcase
      end
      OP_AND:  res = a & b;
      OP_NAND: res = ~(a & b);
      OP_OR:   res = a | b;
      OP_NOR:  res = ~(a | b);
      default: res = '0;
    endcase
    alu_flags            = '0;
    alu_flags[FLAG_OVF]  = ovf;
    alu_flags[FLAG_NEG]  = res[WIDTH-1];
    alu_flags[FLAG_ZERO] = (res == '0);
    alu_flags[FLAG_COUT] = cout;
  end

`ifdef ALU_SEQ_MUL_EN
  logic             mul_start, mul_done;
  logic [WIDTH-1:0] mul_hi, mul_lo;

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .p_hi  (mul_hi),
    .p_lo  (mul_lo)
  );
`endif

  assign bus.in_ready = !rst &&
    (state_q == S_IDLE || (state_q == S_DONE && bus.out_ready));
  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    hi_d    = hi_q;
    flags_d = flags_q;
`ifdef ALU_SEQ_MUL_EN
    mul_start = 1'b0;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE && bus.out_ready) state_d = S_IDLE;
        if (accept) begin
          state_d = S_DONE;
          data_d  = res;
          hi_d    = '0;
          flags_d = alu_flags;
`ifdef ALU_SEQ_MUL_EN
          if (bus.opcode == OP_MUL) begin
            state_d   = S_BUSY;
            mul_start = 1'b1;
          end
`endif
        end
      end
      S_BUSY: begin
`ifdef ALU_SEQ_MUL_EN
        if (mul_done) begin
          state_d = S_DONE;
          data_d  = mul_lo;
          hi_d    = mul_hi;
          flags_d = {1'b0, mul_lo[WIDTH-1], mul_lo == '0, |mul_hi};
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      hi_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      hi_q    <= hi_d;
      flags_q <= flags_d;
    end
  end

  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_data  = data_q;
  assign bus.out_hi    = hi_q;
  assign bus.flags     = flags_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed-vector bench for alu_seq_unit at WIDTH=8.
// MUL vectors run only when ALU_SEQ_MUL_EN is defined.
module tb_alu_seq_unit;
  import alu_seq_pkg::*;

  logic clk;
  logic rst;
  int   vecs = 0;
  int   errs = 0;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq_unit #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run1(input string tag, input logic [3:0] op,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic [7:0] ed,
                      input logic [3:0] ef);
    bus.opcode    = op;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.cin       = c;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.op_a     = ~a;
    bus.op_b     = ~b;
    bus.cin      = ~c;
    bus.opcode   = OP_ADD;
    check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".data"}, 32'(bus.out_data), 32'(ed));
    check({tag, ".hi"}, 32'(bus.out_hi), 32'd0);
    check({tag, ".flags"}, 32'(bus.flags), 32'(ef));
    step();
    check({tag, ".held"}, 32'(bus.out_data), 32'(ed));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, ".retired"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int cyc;
    int stale;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.opcode    = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;

    step();
    check("rst.in_ready", 32'(bus.in_ready), 32'd0);
    check("rst.valid", 32'(bus.out_valid), 32'd0);
    check("rst.data", 32'(bus.out_data), 32'd0);
    check("rst.flags", 32'(bus.flags), 32'd0);
    rst = 1'b0;
    step();
    check("post_rst.in_ready", 32'(bus.in_ready), 32'd1);

    run1("add_ff_01", OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b0011);
    run1("add_ovf", OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b1100);
    run1("add_cin", OP_ADD, 8'h10, 8'h20, 1'b1, 8'h31, 4'b0000);
    run1("sub_80_01", OP_SUB, 8'h80, 8'h01, 1'b1, 8'h7F, 4'b1001);
    run1("sub_borrow", OP_SUB, 8'h05, 8'h07, 1'b1, 8'hFE, 4'b0100);
    run1("lsh", OP_LSH, 8'h81, 8'h00, 1'b1, 8'h03, 4'b0001);
    run1("rsh", OP_RSH, 8'h81, 8'h00, 1'b0, 8'h40, 4'b0001);
    run1("xor", OP_XOR, 8'hA5, 8'h5A, 1'b0, 8'hFF, 4'b0100);
    run1("and", OP_AND, 8'hF0, 8'h0F, 1'b0, 8'h00, 4'b0010);
    run1("nand", OP_NAND, 8'hF0, 8'hFF, 1'b0, 8'h0F, 4'b0000);
    run1("or", OP_OR, 8'h00, 8'h00, 1'b0, 8'h00, 4'b0010);
    run1("nor", OP_NOR, 8'h0F, 8'h30, 1'b0, 8'hC0, 4'b0100);
    run1("illegal_c", 4'hC, 8'h12, 8'h34, 1'b1, 8'h00, 4'b0010);
`ifndef ALU_SEQ_MUL_EN
    run1("mul_off", OP_MUL, 8'hFF, 8'hFF, 1'b0, 8'h00, 4'b0010);
`endif

    // back-to-back compares with the consumer always ready
    bus.out_ready = 1'b1;
    bus.opcode    = OP_CMP;
    bus.in_valid  = 1'b1;
    bus.op_a = 8'd5; bus.op_b = 8'd5;
    step();
    check("b2b.eq.valid", 32'(bus.out_valid), 32'd1);
    check("b2b.eq", 32'(bus.out_data), 32'd1);
    check("b2b.in_ready", 32'(bus.in_ready), 32'd1);
    bus.op_a = 8'd7; bus.op_b = 8'd3;
    step();
    check("b2b.gt", 32'(bus.out_data), 32'd2);
    bus.op_a = 8'd2; bus.op_b = 8'd9;
    step();
    check("b2b.lt", 32'(bus.out_data), 32'd3);
    check("b2b.lt.flags", 32'(bus.flags), 32'd0);
    bus.in_valid = 1'b0;
    step();
    check("b2b.drain", 32'(bus.out_valid), 32'd0);

    // consumer stalls: first result must hold and input must back off
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op_a = 8'd5; bus.op_b = 8'd5;
    step();
    bus.op_a = 8'd7; bus.op_b = 8'd3;
    check("stall.in_ready", 32'(bus.in_ready), 32'd0);
    step();
    check("stall.valid", 32'(bus.out_valid), 32'd1);
    check("stall.held", 32'(bus.out_data), 32'd1);
    bus.out_ready = 1'b1;
    step();
    check("stall.next", 32'(bus.out_data), 32'd2);
    bus.in_valid = 1'b0;
    step();
    check("stall.drain", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // reset while a result is waiting in DONE
    bus.opcode = OP_ADD; bus.op_a = 8'h12; bus.op_b = 8'h34;
    bus.cin = 1'b0; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("rst_done.pre", 32'(bus.out_data), 32'h46);
    rst = 1'b1;
    step();
    check("rst_done.in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    check("rst_done.valid", 32'(bus.out_valid), 32'd0);
    check("rst_done.data", 32'(bus.out_data), 32'd0);

`ifdef ALU_SEQ_MUL_EN
    bus.opcode = OP_MUL; bus.op_a = 8'hFF; bus.op_b = 8'hFF;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.op_a = 8'h00;
    cyc = 1;
    while (bus.out_valid !== 1'b1 && cyc < 20) begin
      check("mul.busy_ready", 32'(bus.in_ready), 32'd0);
      step();
      cyc++;
    end
    check("mul.latency", 32'(cyc), 32'd9);
    check("mul.lo", 32'(bus.out_data), 32'h01);
    check("mul.hi", 32'(bus.out_hi), 32'hFE);
    check("mul.flags", 32'(bus.flags), 32'b0001);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    bus.op_a = 8'hFF; bus.op_b = 8'hFF; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mul_rst.valid", 32'(bus.out_valid), 32'd0);
    check("mul_rst.data", 32'(bus.out_data), 32'd0);
    check("mul_rst.hi", 32'(bus.out_hi), 32'd0);
    check("mul_rst.flags", 32'(bus.flags), 32'd0);
    check("mul_rst.in_ready", 32'(bus.in_ready), 32'd1);
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.out_valid === 1'b1) stale++;
    end
    check("mul_rst.stale", 32'(stale), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
